// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell plus a registered borrow,
// consuming one operand bit per clock, LSB first.
module serial_sub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic             d_bit, b_cell;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      busy     = 1'b0;
      done     = 1'b0;
      d_bit    = sa_q[0] ^ sb_q[0] ^ borrow_q;
      b_cell   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
      case (state_q)
         IDLE: begin
            if (start) begin
               sa_d     = a;
               sb_d     = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            busy     = 1'b1;
            borrow_d = b_cell;
            sa_d     = sa_q >> 1;
            sb_d     = sb_q >> 1;
            // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            diff_d             = diff_q >> 1;
            diff_d[WIDTH-1]    = d_bit;
            cnt_d              = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               bout_d  = b_cell;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign diff = diff_q;
   assign bout = bout_q;

endmodule
